// File: rtl/bridge_pkg.sv
// Shared types and defaults for the H-bridge gate driver.
// Leg FSM encoding and the default break-before-make gap.
package bridge_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_DT_L,
        S_LO,
        S_DT_H,
        S_HI
    } leg_state_t;

    localparam int DEAD_CYCLES_DEF = 4;
    localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/bridge_leg.sv
// One half-bridge leg: break-before-make FSM with dead-time counter.
// Gate outputs are registered from the next-state decode.
module bridge_leg
    import bridge_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic tgt,
    output logic gateH,
    output logic gateL
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    leg_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            gateH   <= 1'b0;
            gateL   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gateH   <= (state_d == S_HI);
            gateL   <= (state_d == S_LO);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            state_d = S_OFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d = S_DT_L;
                    cnt_d   = LOAD;
                end
                S_DT_L: begin
                    if (cnt_q == '0) state_d = S_LO;
                    else             cnt_d   = cnt_q - ONE;
                end
                S_LO: begin
                    if (tgt) begin
                        state_d = S_DT_H;
                        cnt_d   = LOAD;
                    end
                end
                // high side never turned on here, so an early drop is safe
                S_DT_H: begin
                    if (!tgt)              state_d = S_LO;
                    else if (cnt_q == '0)  state_d = S_HI;
                    else                   cnt_d   = cnt_q - ONE;
                end
                S_HI: begin
                    if (!tgt) begin
                        state_d = S_DT_L;
                        cnt_d   = LOAD;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fet_bridge_driver.sv
// Full H-bridge gate driver: target decode, fault latch, two legs.
// Fault takes effect on the same edge it is sampled.
module fet_bridge_driver
    import bridge_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic pwmIn,
    input  logic signIn,
    input  logic faultIn,
    input  logic clearFault,
    output logic gateAH,
    output logic gateAL,
    output logic gateBH,
    output logic gateBL,
    output logic faultLatched
);

    logic tgtA, tgtB;
    logic fault_d;
    logic run;

    assign tgtA = pwmIn & ~signIn;
    assign tgtB = pwmIn & signIn;

    // legs see the latch's next value so gates drop with the fault edge
    assign fault_d = faultIn | (faultLatched & ~clearFault);
    assign run     = enable & ~fault_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) faultLatched <= 1'b0;
        else       faultLatched <= fault_d;
    end

    bridge_leg #(
        .DEAD_CYCLES(DEAD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_leg_a (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tgt  (tgtA),
        .gateH(gateAH),
        .gateL(gateAL)
    );

    bridge_leg #(
        .DEAD_CYCLES(DEAD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_leg_b (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .tgt  (tgtB),
        .gateH(gateBH),
        .gateL(gateBL)
    );

    a_leg_a: assert property (@(posedge clk) disable iff (reset)
        !(gateAH && gateAL));
    a_leg_b: assert property (@(posedge clk) disable iff (reset)
        !(gateBH && gateBL));
    a_highs: assert property (@(posedge clk) disable iff (reset)
        !(gateAH && gateBH));
    a_fault: assert property (@(posedge clk) disable iff (reset)
        !(faultLatched && (gateAH || gateAL || gateBH || gateBL)));

endmodule

// File: tb/tb_fet_bridge_driver.sv
// Directed checks of the H-bridge driver with hand-computed expectations.
// Gate vector order is {AH, AL, BH, BL}.
module tb_fet_bridge_driver;

    logic clk = 1'b0;
    logic reset, enable, pwmIn, signIn, faultIn, clearFault;
    logic gateAH, gateAL, gateBH, gateBL, faultLatched;

    int total = 0;
    int bad   = 0;

    fet_bridge_driver dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pwmIn       (pwmIn),
        .signIn      (signIn),
        .faultIn     (faultIn),
        .clearFault  (clearFault),
        .gateAH      (gateAH),
        .gateAL      (gateAL),
        .gateBH      (gateBH),
        .gateBL      (gateBL),
        .faultLatched(faultLatched)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gates();
        return {gateAH, gateAL, gateBH, gateBL};
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int ah_hi, al_lo, bl_hi, bh_hi, viol, overlap;

        reset = 1'b1; enable = 1'b1; pwmIn = 1'b0; signIn = 1'b0;
        faultIn = 1'b0; clearFault = 1'b0;
        tick(3);
        chk("rst_gates", gates(), 4'b0000);
        chk("rst_fault", faultLatched, 0);

        // release: OFF -> DT_L (1 edge) + 4 dead cycles
        reset = 1'b0;
        tick(4);
        chk("start_dt", gates(), 4'b0000);
        tick(1);
        chk("start_lo", gates(), 4'b0101);

        // PWM period 256, high 128, sign 0
        ah_hi = 0; al_lo = 0; bl_hi = 0; bh_hi = 0;
        for (int i = 0; i < 256; i++) begin
            pwmIn = (i < 128);
            tick(1);
            ah_hi += int'(gateAH);
            al_lo += int'(!gateAL);
            bl_hi += int'(gateBL);
            bh_hi += int'(gateBH);
            if (i == 0) chk("pwm_edge_k", gates(), 4'b0001);
            if (i == 4) chk("pwm_edge_k4", gates(), 4'b1001);
        end
        chk("pwm_ah_hi", ah_hi, 124);
        chk("pwm_al_lo", al_lo, 132);
        chk("pwm_bl_hi", bl_hi, 256);
        chk("pwm_bh_hi", bh_hi, 0);

        // short pulse of 2 cycles
        ah_hi = 0; al_lo = 0;
        for (int i = 0; i < 12; i++) begin
            pwmIn = (i < 2);
            tick(1);
            ah_hi += int'(gateAH);
            al_lo += int'(!gateAL);
        end
        chk("short_ah", ah_hi, 0);
        chk("short_al", al_lo, 2);

        // sign flip while pwm high
        pwmIn = 1'b1; signIn = 1'b0;
        tick(10);
        chk("flip_pre", gates(), 4'b1001);
        signIn = 1'b1;
        overlap = 0;
        tick(1);
        chk("flip_k", gates(), 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            overlap += int'(gateAH & gateBH);
        end
        chk("flip_k3", gates(), 4'b0000);
        tick(1);
        chk("flip_k4", gates(), 4'b0110);
        chk("flip_ovl", overlap, 0);

        // fault during S_HI
        signIn = 1'b0;
        tick(10);
        chk("flt_pre", gates(), 4'b1001);
        faultIn = 1'b1;
        tick(1);
        chk("flt_gates", gates(), 4'b0000);
        chk("flt_latch", faultLatched, 1);
        faultIn = 1'b0;
        tick(1);
        chk("flt_sticky", faultLatched, 1);
        faultIn = 1'b1; clearFault = 1'b1;
        tick(1);
        chk("flt_clr_ign", faultLatched, 1);
        faultIn = 1'b0; pwmIn = 1'b0;
        tick(1);
        chk("flt_clr", faultLatched, 0);
        clearFault = 1'b0;
        tick(3);
        chk("flt_dt", gates(), 4'b0000);
        tick(1);
        chk("flt_lo", gates(), 4'b0101);

        // one-cycle enable drop
        enable = 1'b0;
        tick(1);
        chk("en_off", gates(), 4'b0000);
        enable = 1'b1;
        tick(4);
        chk("en_dt", gates(), 4'b0000);
        tick(1);
        chk("en_lo", gates(), 4'b0101);

        // random soak
        viol = 0;
        for (int i = 0; i < 3000; i++) begin
            pwmIn  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) signIn = ~signIn;
            enable = ($urandom_range(0, 63) != 0);
            tick(1);
            viol += int'((gateAH & gateAL) | (gateBH & gateBL) |
                         (gateAH & gateBH));
        end
        chk("soak_viol", viol, 0);

        // reset asserted mid S_HI
        enable = 1'b1; pwmIn = 1'b1; signIn = 1'b0;
        tick(12);
        chk("rhi_pre", gates(), 4'b1001);
        reset = 1'b1;
        #1;
        chk("rhi_async", gates(), 4'b0000);
        tick(1);
        reset = 1'b0; pwmIn = 1'b0;
        tick(4);
        chk("rhi_dt", gates(), 4'b0000);
        tick(1);
        chk("rhi_lo", gates(), 4'b0101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
